adrv9001_rx_capture: RTL
========================

// Module: adrv9001_rx_capture
// PURPOSE
//  Triggered burst-capture stage directly downstream of the ADRV9001 RX channel, in its divided-clock domain.
//  Accepts packed IQ words {I[15:0],Q[15:0]} qualified by a valid strobe; this stream has no backpressure.
//  Stores a programmed number of samples after a trigger in a small FIFO.
//  Presents the stored samples as an AXI-stream master with tready backpressure and tlast on the final sample.
//  Drops samples and counts overflows when the FIFO is full.
// PARAMETERS
//  DEPTH_LOG2   4    FIFO depth = 2**DEPTH_LOG2 entries (33 bits each: tlast flag + 32-bit data)
//  CNT_WIDTH    16   width of capture_len and the internal sample counter
// PORTS
//  clk            in   1          sample clock (RX divided data clock)
//  rst            in   1          synchronous, active-high reset
//  s_axis_tdata   in   32         IQ sample {I,Q} from RX channel
//  s_axis_tvalid  in   1          sample valid; no ready, sample lost if not taken
//  enable         in   1          level: arm and keep capture active
//  trigger        in   1          single-cycle start pulse, honoured only in ARMED
//  capture_len    in   CNT_WIDTH  samples per burst, latched on IDLE->ARMED; 0 = continuous
//  clear          in   1          sync clear of overflow and overflow_cnt
//  m_axis_tdata   out  32         stored sample
//  m_axis_tvalid  out  1          FIFO not empty
//  m_axis_tready  in   1          downstream accept
//  m_axis_tlast   out  1          final sample of a finite burst
//  busy           out  1          state != IDLE
//  overflow       out  1          sticky: at least one sample dropped
//  overflow_cnt   out  16         dropped-sample count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset:
//   - state IDLE; FIFO emptied; counter 0.
//   - All outputs 0: tvalid, tlast, tdata, busy, overflow, overflow_cnt.
//  States:
//   - IDLE: enable=1 -> ARMED; capture_len latched into len_reg.
//   - ARMED: enable=0 -> IDLE. trigger=1 -> CAPTURE.
//     A valid sample in the trigger cycle is the first captured sample.
//   - CAPTURE: each stored sample increments the counter.
//     If len_reg!=0, the sample making count==len_reg is stored with tlast=1; state -> DRAIN.
//     If len_reg==0, tlast is never set.
//     enable=0 -> DRAIN (abort). A sample in that cycle is not stored; no tlast is generated.
//   - DRAIN: no writes. FIFO empty -> IDLE; re-arms via IDLE next cycle if enable=1.
//  Write rule: a sample is accepted when tvalid & state-qualified & (fifo_cnt < DEPTH | pop).
//   pop = m_axis_tvalid & m_axis_tready; a simultaneous pop and push on a full FIFO succeeds.
//  Drop: a qualified valid sample that is not accepted:
//   - sets overflow; overflow_cnt += 1 (saturating);
//   - does not advance the burst counter (the burst always delivers len_reg stored samples).
//  clear and drop in the same cycle: clear wins, then the count is 1 (overflow=1, overflow_cnt=1).
//  FIFO: first-word-fall-through, circular pointers wrap at DEPTH.
//   - A word written in cycle N drives m_axis_tvalid/tdata/tlast in cycle N+1.
//   - tdata/tlast stay stable while tvalid=1 & tready=0.
//  Empty/full: fifo_cnt range 0..DEPTH. A pop on empty and a push on full without a pop never occur.
//  Samples outside CAPTURE are ignored and are not counted as drops.
//  trigger outside ARMED is ignored.
//  rst mid-burst: abandons the FIFO contents immediately; tvalid=0 on the next cycle.
// TESTING
//  1. len=4, tready=1, 10 contiguous valids from trigger cycle -> 4 words out, 1 cycle latency, tlast on 4th, then IDLE.
//  2. len=0, enable held 20 valids then dropped -> 20 words, no tlast, busy falls after FIFO empties.
//  3. DEPTH=16, len=20, tready=0 for 20 valids -> 16 stored, overflow=1, overflow_cnt=4. Then tready=1 -> burst completes with 4 more samples and tlast on 20th stored.
//  4. Full FIFO, push+pop same cycle -> no drop, fifo_cnt stays 16; clear coincident with a drop -> overflow_cnt=1.
//  5. trigger in IDLE/CAPTURE ignored. rst asserted after 3 of 8 samples -> all outputs 0 next cycle, no residual words.
//  6. Random tready (50%) with len=100 -> output equals input sequence exactly, single tlast, overflow_cnt consistent with a reference model.

Source files
------------

// File: rtl/adrv9001_rx_capture.sv
// ---------------------------------------------------------------------------
// adrv9001_rx_capture
//
// Triggered burst-capture stage behind the ADRV9001 RX channel. It runs in the
// RX divided data-clock domain. IQ words arrive with no backpressure. After a
// trigger, a programmed number of them is stored in a small first-word-fall-
// through FIFO. The FIFO contents are replayed as an AXI-stream master.
// Samples that arrive while the FIFO is full are dropped and counted.
//
// Ports
//   clk, rst            sample clock, synchronous active-high reset
//   s_axis_tdata/tvalid packed {I[15:0],Q[15:0]} sample stream, no ready
//   enable              level: arm and keep capture active
//   trigger             single-cycle start pulse, honoured only in ARMED
//   capture_len         samples per burst, latched on IDLE->ARMED (0 = endless)
//   clear               clears overflow / overflow_cnt
//   m_axis_*            stored-sample AXI-stream master, tlast ends a burst
//   busy                controller is not IDLE
//   overflow            sticky: at least one sample was dropped
//   overflow_cnt        dropped-sample count, saturating
//   dbg_state           controller state (0 IDLE, 1 ARMED, 2 CAPTURE, 3 DRAIN)
//
// Handshake: a word moves on m_axis when m_axis_tvalid & m_axis_tready are both
// high at a rising clk edge. tdata/tlast hold while tvalid=1 and tready=0. The
// input side has no ready: a sample is either stored, dropped, or ignored in
// the cycle it is presented.
// ---------------------------------------------------------------------------
module adrv9001_rx_capture #(
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 enable,
    input  logic                 trigger,
    input  logic [CNT_WIDTH-1:0] capture_len,
    input  logic                 clear,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 busy,
    output logic                 overflow,
    output logic [15:0]          overflow_cnt,
    output logic [1:0]           dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [15:0]            ovf_cnt_q, ovf_cnt_d;

    logic [32:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]    fifo_cnt_q;

    logic                   pop, capture_active, qual, has_space, push, drop;
    logic                   push_last;
    logic [CNT_WIDTH-1:0]   cnt_base, cnt_inc;
    logic [32:0]            rd_word;

    always_comb begin
        pop            = (fifo_cnt_q != '0) & m_axis_tready;
        // The trigger cycle itself already captures, so ARMED+trigger counts.
        capture_active = enable & (((state_q == S_ARMED) & trigger) | (state_q == S_CAPTURE));
        qual           = s_axis_tvalid & capture_active;
        // A pop in the same cycle frees the slot a push on a full FIFO needs.
        has_space      = (fifo_cnt_q < DEPTH_C) | pop;
        push           = qual & has_space;
        drop           = qual & ~has_space;
        // A burst starts counting from zero in its trigger cycle.
        cnt_base       = (state_q == S_CAPTURE) ? cnt_q : '0;
        cnt_inc        = cnt_base + 1'b1;
        push_last      = push & (len_q != '0) & (cnt_inc == len_q);
    end

    // Next-state and controller bookkeeping
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_ARMED;
                    len_d   = capture_len;
                end
            end
            S_ARMED: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (trigger) begin
                    cnt_d   = push ? cnt_inc : cnt_base;
                    state_d = push_last ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!enable) begin
                    state_d = S_DRAIN;
                end else begin
                    if (push)      cnt_d   = cnt_inc;
                    if (push_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_cnt_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A drop coinciding with clear is the first event after the clear.
        if (clear) begin
            ovf_d     = drop;
            ovf_cnt_d = {15'd0, drop};
        end else if (drop) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            ovf_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until fifo_cnt_q says so.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {push_last, s_axis_tdata};
    end

    always_comb begin
        rd_word       = mem_q[rd_ptr_q];
        m_axis_tvalid = (fifo_cnt_q != '0);
        // Gate with tvalid so the outputs read zero while the FIFO is empty.
        m_axis_tdata  = m_axis_tvalid ? rd_word[31:0] : 32'd0;
        m_axis_tlast  = m_axis_tvalid & rd_word[32];
        busy          = (state_q != S_IDLE);
        overflow      = ovf_q;
        overflow_cnt  = ovf_cnt_q;
        dbg_state     = state_q;
    end

endmodule
